// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
//   arb_state_t : arbiter FSM states (HDR is used only when UART_TX_ARB_HDR_EN is defined)
//   HDR_TAG     : upper nibble of the optional per-packet header byte
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      HDR
   } arb_state_t;

   localparam logic [3:0] HDR_TAG = 4'hA;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker.
// Finds the first asserted request searching ptr, ptr+1, ... (mod NUM_SRC).
//   req   in  NUM_SRC  request vector
//   ptr   in  SRC_W    search start index (must be < NUM_SRC)
//   valid out 1        at least one request is set
//   idx   out SRC_W    index of the winning request (0 when none)
module uart_rr_pick #(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned SRC_W   = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [SRC_W-1:0]   ptr,
   output logic               valid,
   output logic [SRC_W-1:0]   idx
);

   logic [SRC_W-1:0] cand;

   always_comb begin
      valid = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         // Modulo keeps the search inside 0..NUM_SRC-1 for non-power-of-2 counts.
         cand = SRC_W'((32'(ptr) + k) % NUM_SRC);
         if (!valid && req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmit byte stream
// between NUM_SRC AXI-Stream sources. A grant is held until the tlast beat is
// accepted, so packets never interleave. Output is a one-entry registered buffer.
// Optional feature macro: UART_TX_ARB_HDR_EN -- when defined, each packet is
// preceded by a header byte {HDR_TAG, grant_id} emitted from an extra HDR state.
//   clk            in   system clock
//   reset          in   synchronous active-high reset
//   s_axis_tdata   in   NUM_SRC*DATA_WIDTH, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_axis_tvalid  in   NUM_SRC per-source valid
//   s_axis_tlast   in   NUM_SRC per-source end-of-packet
//   s_axis_tready  out  NUM_SRC per-source ready (only the granted source can be high)
//   m_axis_tdata   out  DATA_WIDTH byte to the transmitter
//   m_axis_tvalid  out  output valid
//   m_axis_tready  in   transmitter ready
//   grant_id       out  SRC_W current or last granted source
//   busy           out  high while a grant is held
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NUM_SRC    = 4,
   parameter int unsigned SRC_W      = $clog2(NUM_SRC)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_SRC-1:0]            s_axis_tvalid,
   input  logic [NUM_SRC-1:0]            s_axis_tlast,
   output logic [NUM_SRC-1:0]            s_axis_tready,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic [SRC_W-1:0]              grant_id,
   output logic                          busy
);

   arb_state_t            state_q, state_d;
   logic [SRC_W-1:0]      grant_q, grant_d;
   logic [SRC_W-1:0]      ptr_q, ptr_d;
   logic                  busy_q, busy_d;
   logic [DATA_WIDTH-1:0] obuf_data_q, obuf_data_d;
   logic                  obuf_valid_q, obuf_valid_d;

   logic                  loadable;
   logic                  pick_valid;
   logic [SRC_W-1:0]      pick_idx;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  sel_valid;
   logic                  sel_last;
   logic [SRC_W-1:0]      ptr_next;

   uart_rr_pick #(
      .NUM_SRC (NUM_SRC),
      .SRC_W   (SRC_W)
   ) u_pick (
      .req   (s_axis_tvalid),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   // Mux the granted source's beat.
   always_comb begin
      sel_data  = '0;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (grant_q == SRC_W'(i)) begin
            sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            sel_valid = s_axis_tvalid[i];
            sel_last  = s_axis_tlast[i];
         end
      end
   end

   assign loadable = !obuf_valid_q || m_axis_tready;
   assign ptr_next = (grant_q == SRC_W'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      ptr_d         = ptr_q;
      busy_d        = busy_q;
      // Buffer drains on a transfer unless reloaded below.
      obuf_valid_d  = obuf_valid_q && !m_axis_tready;
      obuf_data_d   = obuf_data_q;
      s_axis_tready = '0;

      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               grant_d = pick_idx;
               busy_d  = 1'b1;
`ifdef UART_TX_ARB_HDR_EN
               state_d = HDR;
`else
               state_d = GRANT;
`endif
            end
         end

         HDR: begin
`ifdef UART_TX_ARB_HDR_EN
            if (loadable) begin
               obuf_valid_d = 1'b1;
               obuf_data_d  = DATA_WIDTH'({HDR_TAG, 4'(grant_q)});
               state_d      = GRANT;
            end
`else
            state_d = IDLE;
`endif
         end

         GRANT: begin
            if (loadable) begin
               s_axis_tready[grant_q] = 1'b1;
               if (sel_valid) begin
                  obuf_valid_d = 1'b1;
                  obuf_data_d  = sel_data;
                  if (sel_last) begin
                     ptr_d   = ptr_next;
                     busy_d  = 1'b0;
                     state_d = IDLE;
                  end
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         ptr_q        <= '0;
         busy_q       <= 1'b0;
         obuf_data_q  <= '0;
         obuf_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         ptr_q        <= ptr_d;
         busy_q       <= busy_d;
         obuf_data_q  <= obuf_data_d;
         obuf_valid_q <= obuf_valid_d;
      end
   end

   assign m_axis_tdata  = obuf_data_q;
   assign m_axis_tvalid = obuf_valid_q;
   assign grant_id      = grant_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_SRC=4, DATA_WIDTH=8).
// Inputs change 1ns after posedge; outputs and handshakes are sampled on negedge.
module tb_uart_tx_arbiter;

   logic        clk;
   logic        reset;
   logic [31:0] s_tdata;
   logic [3:0]  s_tvalid;
   logic [3:0]  s_tlast;
   logic [3:0]  s_tready;
   logic [7:0]  m_tdata;
   logic        m_tvalid;
   logic        m_ready;
   logic [1:0]  grant_id;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   logic [7:0] out_q[$];
   logic [7:0] exp_q[$];
   int         src_q[$];
   int         exp_src_q[$];

   bit         stall_en   = 1'b0;
   bit         prev_stall = 1'b0;
   logic [7:0] prev_data  = '0;

   uart_tx_arbiter #(
      .DATA_WIDTH (8),
      .NUM_SRC    (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tlast  (s_tlast),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_ready),
      .grant_id      (grant_id),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Record output transfers and source accepts; check output stability under stall.
   always @(negedge clk) begin
      if (!reset) begin
         if (m_tvalid && m_ready) out_q.push_back(m_tdata);
         for (int i = 0; i < 4; i++)
            if (s_tvalid[i] && s_tready[i]) src_q.push_back(i);
         if (stall_en && prev_stall) begin
            check_eq("stall_valid", {31'd0, m_tvalid}, 32'd1);
            check_eq("stall_data", {24'd0, m_tdata}, {24'd0, prev_data});
         end
      end
      prev_stall = m_tvalid && !m_ready;
      prev_data  = m_tdata;
   end

   // Drive n bytes (byte k = bytes[8k+:8]) from source src; tlast on the final byte if end_pkt.
   task automatic send_pkt(input int src, input int n, input logic [31:0] bytes,
                           input bit end_pkt);
      int cyc;
      for (int k = 0; k < n; k++) begin
         s_tdata[src*8 +: 8] = bytes[k*8 +: 8];
         s_tvalid[src]       = 1'b1;
         s_tlast[src]        = end_pkt && (k == n - 1);
         cyc = 0;
         do begin
            @(negedge clk);
            cyc++;
         end while (!s_tready[src] && cyc < 200);
         if (!s_tready[src]) begin
            check_eq("handshake_timeout", 32'd0, 32'd1);
            break;
         end
         @(posedge clk);
         #1;
      end
      s_tvalid[src] = 1'b0;
      s_tlast[src]  = 1'b0;
   endtask

   // Expected stream for one complete packet.
   task automatic exp_pkt(input int src, input int n, input logic [31:0] bytes);
`ifdef UART_TX_ARB_HDR_EN
      exp_q.push_back(8'hA0 | 8'(src));
`endif
      for (int k = 0; k < n; k++) begin
         exp_q.push_back(bytes[k*8 +: 8]);
         exp_src_q.push_back(src);
      end
   endtask

   task automatic compare_streams(input string tag);
      repeat (6) @(posedge clk);
      #1;
      check_eq({tag, "_out_len"}, out_q.size(), exp_q.size());
      for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
         check_eq({tag, "_out_byte"}, {24'd0, out_q[i]}, {24'd0, exp_q[i]});
      check_eq({tag, "_src_len"}, src_q.size(), exp_src_q.size());
      for (int i = 0; i < src_q.size() && i < exp_src_q.size(); i++)
         check_eq({tag, "_src_order"}, src_q[i], exp_src_q[i]);
      out_q.delete();
      exp_q.delete();
      src_q.delete();
      exp_src_q.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic send_two(input int src);
      send_pkt(src, 1, 32'h40 + src, 1'b1);
      send_pkt(src, 1, 32'h50 + src, 1'b1);
   endtask

   initial begin
      reset    = 1'b1;
      s_tdata  = '0;
      s_tvalid = '0;
      s_tlast  = '0;
      m_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
      check_eq("rst_m_tdata", {24'd0, m_tdata}, 32'd0);
      check_eq("rst_s_tready", {28'd0, s_tready}, 32'd0);
      check_eq("rst_grant_id", {30'd0, grant_id}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Single source: src2 sends 11,22,33.
      exp_pkt(2, 3, 32'h00332211);
      send_pkt(2, 3, 32'h00332211, 1'b1);
      check_eq("single_busy_after_last", {31'd0, busy}, 32'd0);
      check_eq("single_grant_id", {30'd0, grant_id}, 32'd2);
      compare_streams("single");

      // ptr is now 3: src3 must win over src0, then src0.
      exp_pkt(3, 1, 32'h3A);
      exp_pkt(0, 1, 32'h0A);
      fork
         send_pkt(0, 1, 32'h0A, 1'b1);
         send_pkt(3, 1, 32'h3A, 1'b1);
      join
      compare_streams("ptr3");

      // Contention with ptr=0 after reset: src0 packet completes before src3.
      do_reset();
      exp_pkt(0, 2, 32'hB0A0);
      exp_pkt(3, 2, 32'hB3A3);
      fork
         send_pkt(0, 2, 32'hB0A0, 1'b1);
         send_pkt(3, 2, 32'hB3A3, 1'b1);
      join
      compare_streams("contend");

      // Fairness: all four sources continuously requesting 1-byte packets.
      for (int r = 0; r < 2; r++)
         for (int s = 0; s < 4; s++)
            exp_pkt(s, 1, 32'h40 + 32'(r) * 32'h10 + 32'(s));
      fork
         send_two(0);
         send_two(1);
         send_two(2);
         send_two(3);
      join
      compare_streams("fair");

      // Backpressure: tready toggles every cycle during a 4-byte packet.
      stall_en = 1'b1;
      exp_pkt(1, 4, 32'h44332211);
      fork
         send_pkt(1, 4, 32'h44332211, 1'b1);
         begin
            repeat (30) begin
               @(posedge clk);
               #1;
               m_ready = ~m_ready;
            end
         end
      join
      m_ready  = 1'b1;
      stall_en = 1'b0;
      compare_streams("bp");

      // Reset mid-packet (ptr is 2 here): src2 sends 2 of 4 bytes, then reset.
      send_pkt(2, 2, 32'h00006162, 1'b0);
      reset       = 1'b1;
      s_tvalid[2] = 1'b0;
      @(posedge clk);
      #1;
      check_eq("midrst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
      check_eq("midrst_busy", {31'd0, busy}, 32'd0);
      check_eq("midrst_s_tready", {28'd0, s_tready}, 32'd0);
      reset = 1'b0;
      out_q.delete();
      src_q.delete();
      @(posedge clk);
      #1;
      // ptr reset to 0: src1 beats src3.
      exp_pkt(1, 1, 32'hC1);
      exp_pkt(3, 1, 32'hC3);
      fork
         send_pkt(1, 1, 32'hC1, 1'b1);
         send_pkt(3, 1, 32'hC3, 1'b1);
      join
      compare_streams("after_rst");

      // src1 sends 0x55 (header 0xA1 precedes it when the header feature is on).
      exp_pkt(1, 1, 32'h55);
      send_pkt(1, 1, 32'h55, 1'b1);
      compare_streams("hdr");
      check_eq("final_grant_id", {30'd0, grant_id}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1);
   end

endmodule
